// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   state_e  : scan FSM states
//   SEG_OFF  : all segments dark (active-low)
//   HEX_SEG  : hex digit to segment pattern {g,f,e,d,c,b,a}, active-low
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Element [n] holds the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decode (active-low).
//   hex_i : 4-bit digit value
//   seg_o : segments {g,f,e,d,c,b,a}, 0 = lit
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan driver timed off one bit of the upstream
// free-running divider counter. Each rising edge of div_cnt[TAP] advances
// to the next digit through a short all-dark window to avoid ghosting.
// Digit data is snapshotted once per frame so a frame is always coherent.
//   clk, rst   : clock, asynchronous active-high reset
//   div_cnt    : divider counter value (scan timebase = bit TAP)
//   enable     : 1 = scan, 0 = dark/idle
//   data, dp   : per-digit nibbles and decimal points (digit 0 rightmost)
//   blank_lz   : suppress leading zeros
//   an         : anode enables, active-low, one-hot-low when lit
//   seg, dp_n  : segments and decimal point, active-low
//   scan_tick  : one-clock pulse per detected timebase edge (1 clk late)
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int TAP          = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             div_cnt,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    scan_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [3:0]              bcnt_q, bcnt_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpn_q, dpn_d;
  logic                    tap_q, scan_tick_q, tick;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              nib;
  logic [6:0]              nib_seg;
  logic                    lit;

  // Only bit TAP of the counter matters here.
  logic unused_div;
  assign unused_div = ^(div_cnt & ~(32'd1 << TAP));

  assign tick = div_cnt[TAP] & ~tap_q;

  // Leading-zero mask over the snapshot that will be displayed next.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (snap_data_d[4*i +: 4] == 4'h0);
      lz_mask[i] = blank_lz & zero_run & (i != 0);
    end
  end

  assign nib = snap_data_d[{idx_d, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .hex_i (nib),
    .seg_o (nib_seg)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    snap_data_d = snap_data_q;
    snap_dp_d   = snap_dp_q;
    bcnt_d      = bcnt_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      bcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: if (tick) begin
          state_d     = BLANK;
          idx_d       = '0;
          bcnt_d      = '0;
          snap_data_d = data;
          snap_dp_d   = dp;
        end
        // Ticks during the dark window are deliberately dropped.
        BLANK: begin
          if (bcnt_q == 4'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
        SHOW: if (tick) begin
          state_d = BLANK;
          bcnt_d  = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d       = '0;
            snap_data_d = data;
            snap_dp_d   = dp;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs follow the next state so they change on the transition edge.
    lit   = (state_d == SHOW) && !lz_mask[idx_d];
    an_d  = lit ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    seg_d = lit ? nib_seg : SEG_OFF;
    dpn_d = ~(lit & snap_dp_d[idx_d]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      snap_data_q <= '0;
      snap_dp_q   <= '0;
      bcnt_q      <= '0;
      tap_q       <= 1'b0;
      scan_tick_q <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dpn_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_data_q <= snap_data_d;
      snap_dp_q   <= snap_dp_d;
      bcnt_q      <= bcnt_d;
      tap_q       <= div_cnt[TAP];
      scan_tick_q <= tick;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dpn_q       <= dpn_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp_n      = dpn_q;
  assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a frame-level reference model checked every
// cycle, plus directed literal checks of digit order, decode, blanking,
// enable/reset behaviour and tick detection.
module tb_seg7_scan_ctrl;

  localparam int ND  = 4;
  localparam int TP  = 2;
  localparam int BC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] div_cnt = '0;
  logic        enable = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        scan_tick;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b1;

  logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .TAP(TP), .BLANK_CYCLES(BC)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_cnt   (div_cnt),
    .enable    (enable),
    .data      (data),
    .dp        (dp),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .scan_tick (scan_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference model: a frame is "active" from the accepted start tick; the
  // current digit is lit once BC clocks have elapsed since its tick.
  bit          m_prev, m_active, m_tick, m_lit;
  int          m_dig, m_since;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dpn = 1'b1;
  logic        e_tick = 1'b0;

  task automatic model_step();
    logic [3:0] one;
    logic [3:0] nv;
    bit         blnk;
    one = 4'b0001;
    if (rst) begin
      m_prev = 0; m_active = 0; m_dig = 0; m_since = 0;
      m_data = '0; m_dp = '0; m_tick = 0;
    end else begin
      m_tick = div_cnt[TP] && !m_prev;
      m_prev = div_cnt[TP];
      if (!enable) begin
        m_active = 0; m_dig = 0;
      end else if (!m_active) begin
        if (m_tick) begin
          m_active = 1; m_dig = 0; m_since = 0; m_data = data; m_dp = dp;
        end
      end else if (m_since >= BC && m_tick) begin
        m_dig = (m_dig + 1) % ND;
        m_since = 0;
        if (m_dig == 0) begin m_data = data; m_dp = dp; end
      end else if (m_since < BC) begin
        m_since++;
      end
    end
    m_lit = m_active && (m_since >= BC);
    nv    = 4'((m_data >> (4 * m_dig)) & 16'hF);
    blnk  = blank_lz && (m_dig > 0) && ((m_data >> (4 * m_dig)) == 16'h0);
    if (m_lit && !blnk) begin
      e_an = ~(one << m_dig); e_seg = DEC[nv]; e_dpn = !m_dp[m_dig];
    end else begin
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
    end
    e_tick = m_tick;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_an", an, e_an);
    chk("cyc_seg", seg, e_seg);
    chk("cyc_dpn", dp_n, e_dpn);
    chk("cyc_tick", scan_tick, e_tick);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (run) div_cnt = div_cnt + 32'd1;
  endtask

  // Wait for the display to go dark and light again, then check the digit.
  task automatic wait_lit(input string nm, input logic [3:0] ean, input logic [6:0] eseg,
                          input logic edpn, input int edark);
    int n;
    n = 0;
    while (an != 4'hF && n < 64) begin step(); n++; end
    n = 0;
    while (an == 4'hF && n < 64) begin step(); n++; end
    if (n >= 64) begin
      total++; bad++;
      $display("FAIL %s_timeout: display never lit", nm);
    end else begin
      chk({nm, "_an"}, an, ean);
      chk({nm, "_seg"}, seg, eseg);
      chk({nm, "_dpn"}, dp_n, edpn);
      if (edark >= 0) chk({nm, "_dark"}, n, edark);
    end
  endtask

  initial begin
    int cnt;
    #1 rst = 1'b1;
    #2;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dpn", dp_n, 1'b1);
    chk("rst_tick", scan_tick, 1'b0);
    step(); step();
    rst = 1'b0;

    enable = 1'b1; data = 16'h1234; dp = 4'h0; blank_lz = 1'b0;
    wait_lit("d0", 4'b1110, 7'h19, 1'b1, -1);
    wait_lit("d1", 4'b1101, 7'h30, 1'b1, BC);
    wait_lit("d2", 4'b1011, 7'h24, 1'b1, BC);
    data = 16'hABCD; dp = 4'b0010;
    wait_lit("d3", 4'b0111, 7'h79, 1'b1, BC);
    wait_lit("f2d0", 4'b1110, 7'h21, 1'b1, BC);
    wait_lit("f2d1", 4'b1101, 7'h46, 1'b0, BC);
    wait_lit("f2d2", 4'b1011, 7'h03, 1'b1, BC);

    step(); step();
    enable = 1'b0;
    step();
    chk("dis_an", an, 4'hF);
    chk("dis_seg", seg, 7'h7F);
    repeat (12) step();
    chk("dis_hold", an, 4'hF);

    enable = 1'b1; data = 16'h0050; dp = 4'h0; blank_lz = 1'b1;
    wait_lit("lz_d0", 4'b1110, 7'h40, 1'b1, -1);
    wait_lit("lz_d1", 4'b1101, 7'h12, 1'b1, BC);
    wait_lit("lz_wrap", 4'b1110, 7'h40, 1'b1, -1);
    data = 16'h0000;
    wait_lit("lz_old", 4'b1101, 7'h12, 1'b1, BC);
    wait_lit("z_f1", 4'b1110, 7'h40, 1'b1, -1);
    wait_lit("z_f2", 4'b1110, 7'h40, 1'b1, -1);

    #2 rst = 1'b1;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dpn", dp_n, 1'b1);
    step(); step();
    rst = 1'b0;

    wait_lit("post_rst", 4'b1110, 7'h40, 1'b1, -1);
    run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin step(); if (scan_tick) cnt++; end
    chk("hold_ticks", cnt, 0);
    chk("hold_an", an, 4'b1110);

    div_cnt = 32'hFFFF_FFFC;
    repeat (20) step();
    cnt = 0;
    div_cnt = 32'hFFFF_FFFF;
    step(); if (scan_tick) cnt++;
    div_cnt = 32'h0;
    for (int i = 0; i < 6; i++) begin step(); if (scan_tick) cnt++; end
    chk("wrap_ticks", cnt, 0);

    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin step(); if (scan_tick) cnt++; end
    chk("run_ticks", cnt, 4);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Multiplexed seven-segment display driver. It sits directly downstream of the free-running 32-bit clock-divider counter and consumes that counter's value.
- A parameter selects one counter bit as the scan rate. Each rising edge of that bit advances a digit scan.
- Includes an anti-ghosting blank window, a frame-coherent data snapshot, and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, 2..8.
- TAP, 16: index of the div_cnt bit used as the scan timebase, 1..31.
- BLANK_CYCLES, 2: clocks with all anodes off between digits, 1..15. Must be less than 2^(TAP+1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- div_cnt  in  32  free-running counter from the clock divider (registered upstream)
- enable  in  1  1 = scan active; 0 = display dark
- data  in  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost
- dp  in  NUM_DIGITS  decimal point per digit, active-high
- blank_lz  in  1  1 = suppress leading zeros
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low when lit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low
- scan_tick  out  1  registered one-clock pulse, one per detected tick

Behaviour:
- Reset (async, rst=1):
  - an = all ones, seg = 7'h7F, dp_n = 1, scan_tick = 0.
  - state = IDLE, idx = 0, snapshot = 0, tap_q = 0, blank counter = 0.
  - Takes effect immediately, including mid-SHOW or mid-BLANK.
- Tick detection:
  - tap_q <= div_cnt[TAP] every clock.
  - tick = div_cnt[TAP] & ~tap_q (rising edge only).
  - Counter wrap 32'hFFFFFFFF -> 0 gives a falling edge, so no tick.
  - A held div_cnt gives no ticks.
  - scan_tick is tick delayed one clock.
- FSM states IDLE, BLANK, SHOW. All outputs are registered and updated on the same edge as the state transition.
  - IDLE, tick & enable: -> BLANK, idx = 0, snapshot {data, dp} latched.
  - BLANK: an = all ones, seg = 7'h7F, dp_n = 1. After BLANK_CYCLES clocks -> SHOW. Ticks arriving in BLANK are ignored.
  - SHOW: an[idx] = 0, others 1. seg = decode(snapshot nibble idx). dp_n = ~snapshot_dp[idx].
  - SHOW, tick: -> BLANK, idx = (idx+1) mod NUM_DIGITS. When idx wraps to 0, the snapshot is relatched, so a frame is always coherent.
  - Any state, enable = 0: next clock -> IDLE, outputs dark, idx = 0.
  - Simultaneous tick and enable falling: enable wins.
- Timing: if div_cnt[TAP] rises in cycle N, the outputs go dark after edge N. The digit is lit after edge N+BLANK_CYCLES.
- Leading-zero blanking: digit i (i>0) is blanked when blank_lz = 1 and all snapshot nibbles j >= i are zero.
  - A blanked digit keeps an all ones during its SHOW slot and forces dp_n = 1.
  - Digit 0 is never blanked.
- Decode (active-low):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E
- idx width = clog2(NUM_DIGITS). Modulo wrap holds for non-power-of-two NUM_DIGITS.

Decomposition:
- Shared package seg7_pkg:
  - state enum {IDLE, BLANK, SHOW}
  - SEG_OFF = 7'h7F
  - hex-to-segment constant table
- One sub-module: hex_to_seg7, combinational 4-bit to 7-bit decode using the package table. Instantiated once on the selected snapshot nibble.

Test Plan (sim: TAP = 2, BLANK_CYCLES = 2, NUM_DIGITS = 4, div_cnt driven by a model counter):
- data = 16'h1234, dp = 0, enable = 1, blank_lz = 0 -> first tick:
  - 2 clocks with an = 4'hF, then an = 4'b1110, seg = 7'h19.
  - Following ticks: 1101/7'h30, 1011/7'h24, 0111/7'h79, then wrap to 1110.
- Mid-frame data change to 16'hABCD while idx = 2 -> digits 2 and 3 still show 2 and 1. Next frame shows 7'h21, 7'h46, 7'h03, 7'h08.
- blank_lz = 1:
  - data = 16'h0050 -> slots 2 and 3 keep an = 4'hF; digit 1 seg = 7'h12; digit 0 seg = 7'h40.
  - data = 16'h0000 -> only digit 0 lights, seg = 7'h40.
- dp = 4'b0010 -> dp_n = 0 only while an = 4'b1101; dp_n = 1 during BLANK.
- enable dropped in SHOW at idx = 2 -> next clock an = 4'hF, IDLE. Re-enable -> next tick lights digit 0 first.
- rst pulsed asynchronously mid-SHOW -> an = 4'hF, seg = 7'h7F, dp_n = 1 before the next clk edge.
- div_cnt held constant, or wrapping FFFFFFFF -> 0 -> no scan_tick, outputs stay in their prior state.
